// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD sector loader.
package sd_pkg;

  localparam int unsigned WORDS_PER_SEC = 256;
  localparam int unsigned WCNT_W        = 9;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned SEC_W         = 32;
  localparam int unsigned SCNT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_RECV      = 3'd4,
    ST_NEXT      = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

  // Counter runs 0..cyc-1, so clog2(cyc) bits suffice.
  function automatic int unsigned to_cnt_width(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/sd_loader_wr_pack.sv
// Registered write stage: word pointer, overflow suppression and data register.
module sd_loader_wr_pack
  import sd_pkg::*;
#(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_val,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_we,
  output logic [MEM_AW-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_ovf
);

  logic [MEM_AW:0]     r_ptr;
  logic                r_we;
  logic [MEM_AW-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ovf;

  // Pointer stops at 2^MEM_AW; words arriving past it are dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_ovf <= 1'b0;
      if (i_clr) begin
        r_ptr <= '0;
      end else if (i_val) begin
        if (r_ptr[MEM_AW]) begin
          r_ovf <= 1'b1;
        end else begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr[MEM_AW-1:0];
          r_wdata <= i_data;
          r_ptr   <= r_ptr + (MEM_AW+1)'(1);
        end
      end
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/sd_sector_loader.sv
// Sequences consecutive SD sector reads and streams the words into a linear memory.
module sd_sector_loader
  import sd_pkg::*;
#(
  parameter int unsigned MEM_AW        = 12,
  parameter int unsigned TIMEOUT_CYC   = 1000000,
  parameter int unsigned WORDS_PER_SEC = sd_pkg::WORDS_PER_SEC
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              sd_init_done,
  input  logic              load_start,
  input  logic [SEC_W-1:0]  load_base_sec,
  input  logic [SCNT_W-1:0] load_sec_cnt,
  output logic              rd_start_en,
  output logic [SEC_W-1:0]  rd_sec_addr,
  input  logic              rd_busy,
  input  logic              rd_val_en,
  input  logic [DATA_W-1:0] rd_val_data,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned TO_W = to_cnt_width(TIMEOUT_CYC);
  localparam logic [WCNT_W-1:0] WPS     = WCNT_W'(WORDS_PER_SEC);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_e              r_state;
  logic [SEC_W-1:0]    r_base;
  logic [SCNT_W-1:0]   r_cnt;
  logic [SCNT_W-1:0]   r_sec_idx;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_start;
  logic [SEC_W-1:0]    r_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_in_recv;
  logic                w_val_acc;
  logic                w_val_extra;
  logic [WCNT_W-1:0]   w_word_cnt_nxt;
  logic                w_to_hit;
  logic [SCNT_W-1:0]   w_sec_idx_nxt;
  logic                w_clr;
  logic                w_ovf;

  assign w_in_recv      = (r_state == ST_RECV);
  assign w_val_acc      = w_in_recv && rd_val_en && (r_word_cnt != WPS);
  assign w_val_extra    = w_in_recv && rd_val_en && (r_word_cnt == WPS);
  assign w_word_cnt_nxt = r_word_cnt + WCNT_W'(w_val_acc);
  assign w_to_hit       = (r_to_cnt == TO_LAST);
  assign w_sec_idx_nxt  = r_sec_idx + SCNT_W'(1);
  assign w_clr          = (r_state == ST_IDLE) && load_start;

  sd_loader_wr_pack #(
    .MEM_AW (MEM_AW)
  ) u_wr_pack (
    .clk     (clk),
    .rst_n   (sys_rst),
    .i_clr   (w_clr),
    .i_val   (w_val_acc),
    .i_data  (rd_val_data),
    .o_we    (mem_we),
    .o_addr  (mem_addr),
    .o_wdata (mem_wdata),
    .o_ovf   (w_ovf)
  );

  // Sequencing FSM; load_busy tracks "state != IDLE" by being set/cleared on the same edges.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_sec_idx  <= '0;
      r_word_cnt <= '0;
      r_to_cnt   <= '0;
      r_start    <= 1'b0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (w_ovf || w_val_extra) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_base    <= load_base_sec;
            r_cnt     <= load_sec_cnt;
            r_sec_idx <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= (load_sec_cnt == '0) ? ST_FINISH : ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (sd_init_done) begin
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A busy controller here is a leftover read from before reset.
          if (!rd_busy) begin
            r_start  <= 1'b1;
            r_addr   <= r_base + SEC_W'(r_sec_idx);
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (rd_busy) begin
            r_word_cnt <= '0;
            r_to_cnt   <= '0;
            r_state    <= ST_RECV;
          end else if (w_to_hit) begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_RECV: begin
          r_word_cnt <= w_word_cnt_nxt;
          if (!rd_busy) begin
            if (w_word_cnt_nxt != WPS) begin
              r_err   <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_state <= ST_NEXT;
            end
          end else if (w_to_hit) begin
            r_err   <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_NEXT: begin
          r_sec_idx <= w_sec_idx_nxt;
          r_state   <= (w_sec_idx_nxt == r_cnt) ? ST_FINISH : ST_REQ;
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_start_en = r_start;
  assign rd_sec_addr = r_addr;
  assign load_busy   = r_busy;
  assign load_done   = r_done;
  assign load_err    = r_err;

endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed bench for sd_sector_loader with a behavioural SD read controller model.
module tb_sd_sector_loader;

  localparam int unsigned MEM_AW = 9;
  localparam int unsigned TO_CYC = 1000;

  logic        clk;
  logic        sys_rst;
  logic        sd_init_done;
  logic        load_start;
  logic [31:0] load_base_sec;
  logic [15:0] load_sec_cnt;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        rd_val_en;
  logic [15:0] rd_val_data;
  logic        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  sd_sector_loader #(
    .MEM_AW      (MEM_AW),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk           (clk),
    .sys_rst       (sys_rst),
    .sd_init_done  (sd_init_done),
    .load_start    (load_start),
    .load_base_sec (load_base_sec),
    .load_sec_cnt  (load_sec_cnt),
    .rd_start_en   (rd_start_en),
    .rd_sec_addr   (rd_sec_addr),
    .rd_busy       (rd_busy),
    .rd_val_en     (rd_val_en),
    .rd_val_data   (rd_val_data),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state
  int          cyc = 0;
  int          n_req, n_req_busy, n_wr, n_bad, n_done;
  int          req_cyc, done_cyc;
  logic [31:0] req_addr [$];
  logic [MEM_AW-1:0] last_addr;
  logic [31:0] mon_base;

  // Model controls
  int          m_words   = 256;
  bit          m_no_busy = 1'b0;
  logic [31:0] m_sec;
  bit          m_abort;

  function automatic logic [15:0] pat(input logic [31:0] sec, input int idx);
    return {sec[7:0], 8'(idx)} ^ 16'h5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input logic [31:0] base);
    n_req = 0; n_req_busy = 0; n_wr = 0; n_bad = 0; n_done = 0;
    req_cyc = 0; done_cyc = 0; last_addr = '0;
    req_addr.delete();
    mon_base = base;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rd_start_en) begin
      n_req++;
      req_cyc = cyc;
      req_addr.push_back(rd_sec_addr);
      if (rd_busy) n_req_busy++;
    end
    if (mem_we) begin
      if (mem_addr != MEM_AW'(n_wr)) n_bad++;
      if (mem_wdata != pat(mon_base + 32'(n_wr / 256), n_wr % 256)) n_bad++;
      last_addr = mem_addr;
      n_wr++;
    end
    if (load_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // SD read controller model: busy, m_words words with one idle cycle between, busy drop.
  always begin
    @(negedge clk);
    if (rd_start_en && !m_no_busy) begin
      m_sec   = rd_sec_addr;
      m_abort = 1'b0;
      @(posedge clk); #1 rd_busy = 1'b1;
      for (int i = 0; i < m_words; i++) begin
        @(posedge clk); #1;
        if (!sys_rst) begin
          m_abort = 1'b1;
          break;
        end
        rd_val_en   = 1'b1;
        rd_val_data = pat(m_sec, i);
        @(posedge clk); #1 rd_val_en = 1'b0;
      end
      rd_val_en = 1'b0;
      if (m_abort) repeat (20) @(posedge clk);
      @(posedge clk); #1 rd_busy = 1'b0;
    end
  end

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt);
    @(posedge clk); #1;
    load_start    = 1'b1;
    load_base_sec = base;
    load_sec_cnt  = cnt;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int k = 0;
    while (n_done == 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(n_done), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    sys_rst = 1'b0; sd_init_done = 1'b0; load_start = 1'b0;
    load_base_sec = '0; load_sec_cnt = '0;
    rd_busy = 1'b0; rd_val_en = 1'b0; rd_val_data = '0;
    clear_mon(32'h0);
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", 32'({rd_start_en, mem_we, load_busy, load_done, load_err}), 32'h0);
    check_eq("rst_addr", rd_sec_addr, 32'h0);
    check_eq("rst_mem", 32'({mem_addr, mem_wdata}), 32'h0);
    @(posedge clk); #1 sys_rst = 1'b1;

    // Init gating, two sectors from 0x100
    clear_mon(32'h100);
    pulse_start(32'h100, 16'd2);
    repeat (50) @(negedge clk);
    check_eq("gate_noreq", 32'(n_req), 32'd0);
    check_eq("gate_busy", 32'(load_busy), 32'd1);
    #1 sd_init_done = 1'b1;
    wait_done(3000, "gate_done");
    check_eq("gate_nreq", 32'(n_req), 32'd2);
    check_eq("gate_addr0", (req_addr.size() > 0) ? req_addr[0] : 32'hDEAD, 32'h100);
    check_eq("gate_addr1", (req_addr.size() > 1) ? req_addr[1] : 32'hDEAD, 32'h101);
    check_eq("gate_nwr", 32'(n_wr), 32'd512);
    check_eq("gate_last", 32'(last_addr), 32'd511);
    check_eq("gate_bad", 32'(n_bad), 32'd0);
    check_eq("gate_err", 32'(load_err), 32'd0);
    check_eq("gate_idle", 32'(load_busy), 32'd0);

    // Short sector: 255 words, no follow-up request
    clear_mon(32'h40);
    m_words = 255;
    pulse_start(32'h40, 16'd2);
    wait_done(3000, "short_done");
    check_eq("short_err", 32'(load_err), 32'd1);
    check_eq("short_nreq", 32'(n_req), 32'd1);
    check_eq("short_nwr", 32'(n_wr), 32'd255);
    m_words = 256;

    // Zero count: immediate finish, error cleared by the new start
    clear_mon(32'h50);
    pulse_start(32'h50, 16'd0);
    wait_done(4, "zero_done");
    check_eq("zero_nreq", 32'(n_req), 32'd0);
    check_eq("zero_nwr", 32'(n_wr), 32'd0);
    check_eq("zero_err", 32'(load_err), 32'd0);

    // Timeout: controller never goes busy
    clear_mon(32'h60);
    m_no_busy = 1'b1;
    pulse_start(32'h60, 16'd1);
    wait_done(1200, "to_done");
    check_eq("to_err", 32'(load_err), 32'd1);
    check_eq("to_nreq", 32'(n_req), 32'd1);
    check_eq("to_delay", 32'((done_cyc - req_cyc) >= 1000 && (done_cyc - req_cyc) <= 1003), 32'd1);
    m_no_busy = 1'b0;

    // Overflow with sector address wrap: 3 sectors into a 512-word space
    clear_mon(32'hFFFF_FFFF);
    pulse_start(32'hFFFF_FFFF, 16'd3);
    wait_done(4000, "ovf_done");
    check_eq("ovf_nreq", 32'(n_req), 32'd3);
    check_eq("ovf_addr1", (req_addr.size() > 1) ? req_addr[1] : 32'hDEAD, 32'h0);
    check_eq("ovf_addr2", (req_addr.size() > 2) ? req_addr[2] : 32'hDEAD, 32'h1);
    check_eq("ovf_nwr", 32'(n_wr), 32'd512);
    check_eq("ovf_last", 32'(last_addr), 32'd511);
    check_eq("ovf_bad", 32'(n_bad), 32'd0);
    check_eq("ovf_err", 32'(load_err), 32'd1);

    // Reset mid-RECV, then stale busy from the controller
    clear_mon(32'h70);
    pulse_start(32'h70, 16'd1);
    begin
      int k = 0;
      while (n_wr < 100 && k < 1000) begin
        @(negedge clk);
        k++;
      end
    end
    check_eq("rr_reached", 32'(n_wr >= 100), 32'd1);
    #1 sys_rst = 1'b0;
    #1 check_eq("rr_outs", 32'({rd_start_en, mem_we, load_busy, load_done, load_err}), 32'h0);
    repeat (3) @(negedge clk);
    check_eq("rr_nodone", 32'(n_done), 32'd0);
    @(posedge clk); #1 sys_rst = 1'b1;
    clear_mon(32'h200);
    pulse_start(32'h200, 16'd1);
    repeat (3) @(negedge clk);
    pulse_start(32'h300, 16'd5);
    check_eq("rr_waitreq", 32'(n_req), 32'd0);
    check_eq("rr_busy", 32'(load_busy), 32'd1);
    wait_done(2000, "rr_done");
    check_eq("rr_nreq", 32'(n_req), 32'd1);
    check_eq("rr_addr", (req_addr.size() > 0) ? req_addr[0] : 32'hDEAD, 32'h200);
    check_eq("rr_reqbusy", 32'(n_req_busy), 32'd0);
    check_eq("rr_nwr", 32'(n_wr), 32'd256);
    check_eq("rr_bad", 32'(n_bad), 32'd0);
    check_eq("rr_err", 32'(load_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_sector_loader.md
Name: sd_sector_loader

Overview:
- Downstream consumer and sequencer of the SD read controller.
- Waits for sd_init_done, then issues a run of consecutive sector reads starting at a base sector.
- Packs the returned 16-bit words into a linear word-addressed memory write port, e.g. to boot-load program/data RAM for the CPU.
- Reports completion or error to the requester.

Parameters:
- MEM_AW, 12, word address width of the target memory write port.
- TIMEOUT_CYC, 1000000, maximum cycles to wait for rd_busy to rise after a request, or for a sector read to finish.
- WORDS_PER_SEC, 256, 16-bit words per 512-byte sector (constant, not to be overridden).

Ports:
- clk  input  1  system clock (same clock as the SD controller)
- sys_rst  input  1  asynchronous active-low reset
- sd_init_done  input  1  SD card initialisation complete
- load_start  input  1  single-cycle request to start a load
- load_base_sec  input  32  first sector address, sampled on load_start
- load_sec_cnt  input  16  number of sectors to load, sampled on load_start
- rd_start_en  output  1  single-cycle read request to the SD read controller
- rd_sec_addr  output  32  sector address for the current request
- rd_busy  input  1  SD read controller busy
- rd_val_en  input  1  read data word valid
- rd_val_data  input  16  read data word
- mem_we  output  1  memory write strobe
- mem_addr  output  MEM_AW  memory word address
- mem_wdata  output  16  memory write data
- load_busy  output  1  load in progress
- load_done  output  1  single-cycle pulse, load finished (success or error)
- load_err  output  1  sticky error flag, cleared on the next accepted load_start

Behaviour:
- Clock and reset: one clock (clk); reset sys_rst is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, WAIT_INIT, REQ, WAIT_ACK, RECV, NEXT, FINISH.
- IDLE:
  - load_start accepted → latch base/count, clear load_err, clear word pointer.
  - If load_sec_cnt == 0 → FINISH.
  - Otherwise → WAIT_INIT.
  - load_start is ignored in every other state.
- WAIT_INIT: stay until sd_init_done = 1, then → REQ.
- REQ:
  - Entered only while rd_busy = 0; if rd_busy = 1 (stale read after reset), wait here.
  - Assert rd_start_en for exactly 1 cycle with rd_sec_addr = base + sector index, then → WAIT_ACK.
- WAIT_ACK:
  - rd_busy = 1 → RECV; reset the in-sector word counter and the timeout counter.
  - TIMEOUT_CYC cycles without rd_busy → set load_err, → FINISH.
- RECV:
  - Each rd_val_en writes rd_val_data.
  - On rd_busy falling (rd_busy = 0): if in-sector count != 256 → load_err, → FINISH; else → NEXT.
  - Timeout while in RECV → load_err, → FINISH.
- NEXT: increment the sector index; if index == load_sec_cnt → FINISH, else → REQ.
- FINISH: load_done = 1 for 1 cycle, → IDLE.
- rd_sec_addr: held stable from REQ until the FSM leaves RECV. 32-bit address arithmetic wraps modulo 2^32.
- Write path:
  - rd_val_en at cycle t → mem_we = 1 at t+1.
  - mem_wdata = word received at t.
  - mem_addr = word pointer; pointer then post-increments.
- Overflow:
  - Word pointer reaching 2^MEM_AW: further writes suppressed (mem_we = 0) and load_err set.
  - The load still runs to the last sector, then FINISH.
- Words beyond 256 within one sector: not written, load_err set.
- load_busy = 1 in every state except IDLE.
- Reset mid-operation: immediate return to IDLE, rd_start_en and mem_we deasserted, no load_done pulse.

Decomposition:
- Shared package (sd_pkg): WORDS_PER_SEC = 256, the state encoding constants, and the timeout counter width derived from TIMEOUT_CYC.
- One natural sub-module: sd_loader_wr_pack. It holds the registered write stage: word pointer, overflow detection and 1-cycle data register.
- Sequencing FSM stays in the top of this block.

Test Plan:
- Init gating: load_start (base=0x100, cnt=2) with sd_init_done=0 for 50 cycles → no rd_start_en until sd_init_done rises; then rd_start_en pulses at addr 0x100, then 0x101; 512 writes to addr 0..511; load_done pulse; load_err=0.
- Zero count: load_start with cnt=0 → load_done 1 cycle later (FINISH), no rd_start_en, no mem_we.
- Short sector: model returns 255 words for sector 0 → load_err=1, load_done pulse, no request for sector 1.
- Timeout: model never raises rd_busy, with TIMEOUT_CYC=100 → load_err=1 and load_done pulse ~100 cycles after rd_start_en.
- Overflow: MEM_AW=8, cnt=2 → exactly 256 writes (addr 0..255), second sector's words suppressed, load_err=1, load_done after sector 2 completes.
- Reset mid-RECV, then a stale rd_busy held high 20 cycles:
  - Outputs go 0 immediately.
  - A new load_start waits in REQ until rd_busy=0 before pulsing rd_start_en.
  - load_start pulses while busy are ignored (sampled base unchanged).
